// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   arb_state_t  : arbiter FSM state (normal sharing / post-forced-grant guard)
//   STARVE_CNT_W : width of the DMA starvation counter
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic [0:0] {
    ARB_NORMAL = 1'b0,
    ARB_GUARD  = 1'b1
  } arb_state_t;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arb_starve_ctr.sv
// ---------------------------------------------------------------------------
// dmem_arb_starve_ctr
// Saturating counter of consecutive cycles the DMA port has lost arbitration.
// Clear has priority over increment; the count stops at LIMIT.
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset
//   clr_i    clear the count (DMA granted or not requesting)
//   inc_i    conflict cycle: count up, saturating at LIMIT
//   cnt_o    current count
//   limit_o  count has reached LIMIT (forced grant allowed)
// ---------------------------------------------------------------------------
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    inc_i,
  output logic [STARVE_CNT_W-1:0] cnt_o,
  output logic                    limit_o
);

  localparam logic [STARVE_CNT_W-1:0] LimitC = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_d, cnt_q;

  assign limit_o = (cnt_q == LimitC);
  assign cnt_o   = cnt_q;

  // NOTE: the next value is assigned a default first, so every path through
  // the block drives cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !limit_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : dmem_arb_starve_ctr

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-ported data memory between the pipeline MEM stage (CPU)
// and a DMA/debug loader. The CPU owns the memory by default; the DMA is
// served in idle CPU cycles, or forced in after STARVE_LIMIT consecutive
// conflict cycles, stalling the pipeline for that one cycle. The cycle after
// a forced grant always belongs to the CPU (guard state).
// The CPU read path is combinational; DMA read data returns one cycle after
// the grant with a one-cycle valid pulse.
//
// Optional feature (macro DMEM_ARB_STATS_EN): adds 32-bit wrapping counters
// stall_cnt_o (cycles with cpu_stall_o high) and dma_cnt_o (DMA grant cycles).
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i CPU (MEM stage) access request
//   cpu_rdata_o                   CPU read data (combinational)
//   cpu_stall_o                   freeze pipeline; CPU holds its request
//   dma_req_i/we_i/addr_i/wdata_i DMA access request, held until granted
//   dma_gnt_o                     DMA access performed this cycle
//   dma_rdata_o, dma_rvalid_o     registered DMA read data + valid pulse
//   mem_we_o/addr_o/wdata_o       data memory write/address/data
//   mem_rdata_i                   data memory read data (combinational)
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_rvalid_o,
`ifdef DMEM_ARB_STATS_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       dma_cnt_o,
`endif
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_t state_d, state_q;

  logic              conflict;
  logic              dma_gnt;
  logic              starve_limit;
  logic              rvalid_d, rvalid_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Count is only observed through starve_limit.
  logic [STARVE_CNT_W-1:0] starve_cnt;

  assign conflict = cpu_req_i && dma_req_i;

  dmem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (dma_gnt || !dma_req_i),
    .inc_i   (conflict),
    .cnt_o   (starve_cnt),
    .limit_o (starve_limit)
  );

  // Grant decision and next state. The grant is gated by rst so no memory
  // write or stall can escape while the block is held in reset.
  always_comb begin
    state_d = state_q;
    dma_gnt = 1'b0;
    unique case (state_q)
      ARB_NORMAL: begin
        dma_gnt = dma_req_i && (!cpu_req_i || starve_limit);
        if (conflict && dma_gnt) begin
          state_d = ARB_GUARD;
        end
      end
      ARB_GUARD: begin
        dma_gnt = dma_req_i && !cpu_req_i;
        state_d = ARB_NORMAL;
      end
      default: state_d = ARB_NORMAL;
    endcase
    if (!rst) begin
      dma_gnt = 1'b0;
    end
  end

  assign dma_gnt_o   = dma_gnt;
  assign cpu_stall_o = cpu_req_i && dma_gnt;
  assign cpu_rdata_o = mem_rdata_i;

  // Memory mux: a stalled CPU store is dropped because the DMA owns the port.
  always_comb begin
    if (dma_gnt) begin
      mem_we_o    = dma_we_i;
      mem_addr_o  = dma_addr_i;
      mem_wdata_o = dma_wdata_i;
    end else begin
      mem_we_o    = rst && cpu_req_i && cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
    end
  end

  // DMA read return: capture on a granted read, hold otherwise.
  assign rvalid_d = dma_gnt && !dma_we_i;
  assign rdata_d  = rvalid_d ? mem_rdata_i : rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_NORMAL;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dma_rvalid_o = rvalid_q;
  assign dma_rdata_o  = rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stall_cnt_q, dma_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      dma_cnt_q   <= '0;
    end else begin
      if (cpu_stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (dma_gnt)     dma_cnt_q   <= dma_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign dma_cnt_o   = dma_cnt_q;
`endif

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. Instance u_dut_a uses STARVE_LIMIT=4 with a
// small word memory model; u_dut_b uses STARVE_LIMIT=0 and shares the inputs.
// Inputs change 1ns after the rising edge; outputs are checked on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

  // Instance A outputs
  logic [31:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_cpu_stall, a_dma_gnt, a_dma_rvalid, a_mem_we;
  // Instance B outputs
  logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata;
  logic        b_cpu_stall, b_dma_gnt, b_dma_rvalid, b_mem_we;
  logic [31:0] b_mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] a_stall_cnt, a_dma_cnt, b_stall_cnt, b_dma_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Word-addressed memory model behind instance A.
  logic [31:0] mem_a [0:255];
  assign a_mem_rdata = mem_a[a_mem_addr[9:2]];
  always @(posedge clk) if (a_mem_we) mem_a[a_mem_addr[9:2]] <= a_mem_wdata;
  assign b_mem_rdata = 32'h0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) u_dut_a (
    .clk (clk), .rst (rst),
    .cpu_req_i (cpu_req), .cpu_we_i (cpu_we), .cpu_addr_i (cpu_addr),
    .cpu_wdata_i (cpu_wdata), .cpu_rdata_o (a_cpu_rdata), .cpu_stall_o (a_cpu_stall),
    .dma_req_i (dma_req), .dma_we_i (dma_we), .dma_addr_i (dma_addr),
    .dma_wdata_i (dma_wdata), .dma_gnt_o (a_dma_gnt), .dma_rdata_o (a_dma_rdata),
    .dma_rvalid_o (a_dma_rvalid),
`ifdef DMEM_ARB_STATS_EN
    .stall_cnt_o (a_stall_cnt), .dma_cnt_o (a_dma_cnt),
`endif
    .mem_we_o (a_mem_we), .mem_addr_o (a_mem_addr), .mem_wdata_o (a_mem_wdata),
    .mem_rdata_i (a_mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(0)) u_dut_b (
    .clk (clk), .rst (rst),
    .cpu_req_i (cpu_req), .cpu_we_i (cpu_we), .cpu_addr_i (cpu_addr),
    .cpu_wdata_i (cpu_wdata), .cpu_rdata_o (b_cpu_rdata), .cpu_stall_o (b_cpu_stall),
    .dma_req_i (dma_req), .dma_we_i (dma_we), .dma_addr_i (dma_addr),
    .dma_wdata_i (dma_wdata), .dma_gnt_o (b_dma_gnt), .dma_rdata_o (b_dma_rdata),
    .dma_rvalid_o (b_dma_rvalid),
`ifdef DMEM_ARB_STATS_EN
    .stall_cnt_o (b_stall_cnt), .dma_cnt_o (b_dma_cnt),
`endif
    .mem_we_o (b_mem_we), .mem_addr_o (b_mem_addr), .mem_wdata_o (b_mem_wdata),
    .mem_rdata_i (b_mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wdata;
  endtask

  // Expected grant patterns for held conflict, one bit per cycle (bit 0 first).
  logic [9:0] starve_pat;
  logic [4:0] wait_pat;
  logic [5:0] alt_pat;

  initial begin
    starve_pat = 10'b10000_10000;   // grants on cycles 5 and 10
    wait_pat   = 5'b10000;          // grant on 5th conflict cycle
    alt_pat    = 6'b010101;         // 1,0,1,0,1,0

    // Reset with every request asserted: outputs forced low.
    rst = 1'b0;
    set_cpu(1'b1, 1'b1, 32'h40, 32'h55);
    set_dma(1'b1, 1'b1, 32'h40, 32'h66);
    repeat (2) @(negedge clk);
    check("rst_gnt",    {31'd0, a_dma_gnt},    32'd0);
    check("rst_stall",  {31'd0, a_cpu_stall},  32'd0);
    check("rst_mem_we", {31'd0, a_mem_we},     32'd0);
    check("rst_rvalid", {31'd0, a_dma_rvalid}, 32'd0);

    // Release with no requests.
    cyc();
    rst = 1'b1;
    set_cpu(1'b0, 1'b0, 32'h40, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("idle_gnt",    {31'd0, a_dma_gnt},    32'd0);
    check("idle_stall",  {31'd0, a_cpu_stall},  32'd0);
    check("idle_mem_we", {31'd0, a_mem_we},     32'd0);
    check("idle_rvalid", {31'd0, a_dma_rvalid}, 32'd0);
    check("idle_rdata",  a_dma_rdata,           32'd0);

    // DMA write DEADBEEF to 0x40 while CPU idle: same-cycle grant, no rvalid.
    cyc();
    set_dma(1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    check("dwr_gnt",    {31'd0, a_dma_gnt}, 32'd1);
    check("dwr_mem_we", {31'd0, a_mem_we},  32'd1);
    check("dwr_wdata",  a_mem_wdata,        32'hDEADBEEF);
    cyc();
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("dwr_no_rvalid", {31'd0, a_dma_rvalid}, 32'd0);
    check("cpu_rdata_comb", a_cpu_rdata,          32'hDEADBEEF);

    // DMA read of 0x40 with CPU idle.
    cyc();
    set_dma(1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    check("drd_gnt",    {31'd0, a_dma_gnt},   32'd1);
    check("drd_stall",  {31'd0, a_cpu_stall}, 32'd0);
    check("drd_addr",   a_mem_addr,           32'h40);
    check("drd_mem_we", {31'd0, a_mem_we},    32'd0);
    cyc();
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("drd_rvalid", {31'd0, a_dma_rvalid}, 32'd1);
    check("drd_rdata",  a_dma_rdata,           32'hDEADBEEF);
    cyc();
    @(negedge clk);
    check("drd_rvalid_pulse", {31'd0, a_dma_rvalid}, 32'd0);
    check("drd_rdata_hold",   a_dma_rdata,           32'hDEADBEEF);

    // Held conflict (reads): forced grants on cycles 5 and 10.
    cyc();
    set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
    set_dma(1'b1, 1'b0, 32'h44, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("starve_gnt[%0d]", i),   {31'd0, a_dma_gnt},   {31'd0, starve_pat[i]});
      check($sformatf("starve_stall[%0d]", i), {31'd0, a_cpu_stall}, {31'd0, starve_pat[i]});
      if (i == 5) check("starve_rvalid", {31'd0, a_dma_rvalid}, 32'd1);
      cyc();
    end
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);

    // Forced DMA write 0x11 colliding with CPU store 0x22, both to 0x80.
    cyc();
    set_cpu(1'b1, 1'b1, 32'h80, 32'h22);
    set_dma(1'b1, 1'b1, 32'h80, 32'h11);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("coll_wait_gnt[%0d]", i), {31'd0, a_dma_gnt}, 32'd0);
      check($sformatf("coll_wait_wd[%0d]", i),  a_mem_wdata,        32'h22);
      cyc();
    end
    @(negedge clk);
    check("coll_gnt",    {31'd0, a_dma_gnt},   32'd1);
    check("coll_stall",  {31'd0, a_cpu_stall}, 32'd1);
    check("coll_mem_we", {31'd0, a_mem_we},    32'd1);
    check("coll_wdata",  a_mem_wdata,          32'h11);
    cyc();
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("coll_mem_after_dma", mem_a[8'h20],         32'h11);
    check("guard_gnt",          {31'd0, a_dma_gnt},   32'd0);
    check("guard_stall",        {31'd0, a_cpu_stall}, 32'd0);
    check("guard_mem_we",       {31'd0, a_mem_we},    32'd1);
    check("guard_wdata",        a_mem_wdata,          32'h22);
    check("guard_no_rvalid",    {31'd0, a_dma_rvalid}, 32'd0);
    cyc();
    set_cpu(1'b0, 1'b0, 32'h80, 32'h0);
    @(negedge clk);
    check("coll_final_mem", a_cpu_rdata, 32'h22);

    // DMA drops its request mid-wait: the starvation count restarts.
    cyc();
    set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
    set_dma(1'b1, 1'b0, 32'h44, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("drop_wait_gnt", {31'd0, a_dma_gnt}, 32'd0);
      cyc();
    end
    dma_req = 1'b0;
    @(negedge clk);
    check("drop_gnt", {31'd0, a_dma_gnt}, 32'd0);
    cyc();
    dma_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("drop_regnt[%0d]", i), {31'd0, a_dma_gnt}, {31'd0, wait_pat[i]});
      cyc();
    end
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);

    // Reset right after a forced DMA read grant: read lost, FSM back to normal.
    cyc();
    set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
    set_dma(1'b1, 1'b0, 32'h40, 32'h0);
    repeat (4) cyc();
    @(negedge clk);
    check("rmid_gnt", {31'd0, a_dma_gnt}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rmid_rvalid_rst", {31'd0, a_dma_rvalid}, 32'd0);
    check("rmid_stall_rst",  {31'd0, a_cpu_stall},  32'd0);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rmid_regnt[%0d]", i), {31'd0, a_dma_gnt}, {31'd0, wait_pat[i]});
      if (i == 0) check("rmid_rvalid_after", {31'd0, a_dma_rvalid}, 32'd0);
      cyc();
    end

    // STARVE_LIMIT=0 (instance B): continuous conflict alternates.
    rst = 1'b0;
    @(negedge clk);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("alt_gnt[%0d]", i),   {31'd0, b_dma_gnt},   {31'd0, alt_pat[i]});
      check($sformatf("alt_stall[%0d]", i), {31'd0, b_cpu_stall}, {31'd0, alt_pat[i]});
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dmem_arbiter

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between the pipeline MEM stage (CPU port) and a DMA/debug loader port (DMA port).
- CPU owns the memory by default. DMA is served in idle CPU cycles, or is forced in after a bounded wait, in which case the arbiter stalls the pipeline.
- Sits between the memory-stage logic and the data memory instance.
- CPU read path stays combinational, so existing MEM/WB pipeline register timing is unchanged.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive conflict cycles the DMA waits before a forced grant. Range 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cpu_req_i  in  1  MEM stage accesses memory this cycle (load or store)
- cpu_we_i  in  1  CPU write enable
- cpu_addr_i  in  ADDR_W  CPU address (ALU result)
- cpu_wdata_i  in  DATA_W  CPU store data
- cpu_rdata_o  out  DATA_W  CPU read data, combinational
- cpu_stall_o  out  1  freeze the pipeline; CPU must hold its request
- dma_req_i  in  1  DMA request; held until granted
- dma_we_i  in  1  DMA write enable
- dma_addr_i  in  ADDR_W  DMA address
- dma_wdata_i  in  DATA_W  DMA write data
- dma_gnt_o  out  1  DMA access performed this cycle
- dma_rdata_o  out  DATA_W  DMA read data, registered
- dma_rvalid_o  out  1  one-cycle pulse: dma_rdata_o valid
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, combinational

Behaviour:
- Reset (rst low): state=ARB_NORMAL, starve_cnt=0, dma_rdata_o=0, dma_rvalid_o=0. While rst is low, mem_we_o, dma_gnt_o and cpu_stall_o are forced to 0.
- Conflict means cpu_req_i and dma_req_i are both high.
- FSM states:
  - ARB_NORMAL:
    - dma_gnt_o = dma_req_i && (!cpu_req_i || starve_cnt==STARVE_LIMIT).
    - On a forced grant (conflict with dma_gnt_o high), go to ARB_GUARD.
  - ARB_GUARD:
    - dma_gnt_o = dma_req_i && !cpu_req_i.
    - Always returns to ARB_NORMAL next cycle.
    - Guarantees the CPU one cycle after every forced grant, so STARVE_LIMIT=0 yields strict alternation rather than a permanent stall.
- cpu_stall_o = cpu_req_i && dma_gnt_o.
- Memory mux:
  - When dma_gnt_o is high, mem_* is driven by dma_*.
  - Otherwise mem_* is driven by cpu_*, with mem_we_o = cpu_req_i && cpu_we_i.
  - A stalled CPU store never reaches memory.
- cpu_rdata_o = mem_rdata_i unconditionally. The CPU side ignores it while stalled.
- starve_cnt (sequential):
  - Cleared when dma_gnt_o is high or dma_req_i is low.
  - Otherwise increments on each conflict cycle, saturating at STARVE_LIMIT.
  - Width is 4 bits.
- DMA read return: on a granted read (dma_gnt_o && !dma_we_i), register dma_rdata_o <= mem_rdata_i and set dma_rvalid_o=1 in the next cycle. Otherwise dma_rvalid_o=0. Latency is 1 cycle after grant.
- DMA writes complete in the grant cycle with no rvalid. Back-to-back DMA grants give one rvalid per read.
- DMA port with cpu_req_i low: granted the same cycle, with zero stall.
- dma_req_i dropped before grant: counter clears and no access occurs.
- Reset mid-access: the in-flight DMA read is lost (rvalid not pulsed) and the FSM returns to ARB_NORMAL.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stall_cnt_o (32-bit, counts cycles with cpu_stall_o high) and dma_cnt_o (32-bit, counts dma_gnt_o cycles).
  - Both counters wrap on overflow and reset to 0.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Shared package dmem_arb_pkg:
  - enum arb_state_t {ARB_NORMAL, ARB_GUARD}
  - constant STARVE_CNT_W=4
- Sub-module: dmem_arb_starve_ctr, the saturating starvation counter with clear/increment and a limit-reached output. The FSM, mux and DMA return register stay in the top.

Test Plan:
- Reset release with no requests -> all outputs 0, mem_we_o=0, dma_rvalid_o=0.
- DMA read addr 0x40 (mem holds 0xDEADBEEF) with cpu_req_i=0 -> dma_gnt_o=1 in the same cycle, cpu_stall_o=0; next cycle dma_rvalid_o=1, dma_rdata_o=0xDEADBEEF.
- STARVE_LIMIT=4, cpu_req_i and dma_req_i held high:
  - DMA waits 4 cycles, then is granted on the 5th cycle with cpu_stall_o=1.
  - 6th cycle (ARB_GUARD): CPU served.
  - 7th cycle onward: DMA waits again (stalls only after a further 4 wait cycles).
- Forced DMA write 0x11 to 0x80 coinciding with CPU store 0x22 to 0x80 -> mem gets 0x11 in the stall cycle. CPU store completes in the guard cycle; final mem[0x80]=0x22.
- STARVE_LIMIT=0 with continuous conflict -> dma_gnt_o alternates 1,0,1,0 and cpu_stall_o matches it.
- rst asserted the cycle after a granted DMA read -> dma_rvalid_o stays 0; after release, the FSM is in ARB_NORMAL and starve_cnt=0.
